// File: rtl/led_trail_pwm.sv
// -----------------------------------------------------------------------------
// led_trail_pwm
//
// Purpose:
//   Turns each bit of the LED pattern register into a per-LED brightness level
//   that decays after the bit clears (a fading "comet trail"). Each level is
//   rendered as a PWM waveform that drives the board LEDs directly.
//
//   Every period of the free-running PWM counter is MAX cycles long
//   (MAX = 2**LEVEL_W-1). At the last cycle of a period the levels are copied
//   into per-LED shadow duty registers. The output compares against the shadow
//   copy, so a level change never glitches the waveform mid-period.
//
// Handshake:
//   step is a single-cycle strobe with no backpressure. pattern is valid only
//   in a cycle where step=1. Each strobe advances the trail by one step.
//   There is no ready signal: the block accepts a strobe on every cycle.
//
// Configuration macro:
//   LED_GAMMA_EN  when defined, duty(l) = (l*l + MAX-1) / MAX (a coarse gamma
//                 curve). When undefined, duty(l) = l (linear).
//
// Parameters:
//   N_LEDS     number of LEDs / pattern width
//   LEVEL_W    brightness level width; MAX = 2**LEVEL_W-1
//   DECAY_DIV  number of steps per one-level decay (>= 1)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   clear        synchronous active-high reset, overrides everything
//   step         one-cycle strobe: pattern valid, advance the trail
//   pattern      current LED pattern, sampled only when step=1
//   led_out      registered PWM drive, one bit per LED
//   frame_pulse  registered, high for the first led_out cycle of each period
// -----------------------------------------------------------------------------
module led_trail_pwm #(
    parameter int N_LEDS    = 8,
    parameter int LEVEL_W   = 3,
    parameter int DECAY_DIV = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              step,
    input  logic [N_LEDS-1:0] pattern,
    output logic [N_LEDS-1:0] led_out,
    output logic              frame_pulse
);

    localparam logic [LEVEL_W-1:0] MAX      = {LEVEL_W{1'b1}};
    localparam logic [LEVEL_W-1:0] PWM_LAST = MAX - 1'b1;

    // Intermediate width for the gamma product. It holds MAX*MAX + MAX-1
    // without overflow.
    localparam logic [2*LEVEL_W-1:0] MAX_W    = {{LEVEL_W{1'b0}}, MAX};
    localparam logic [2*LEVEL_W-1:0] MAX_M1_W = MAX_W - 1'b1;

    // The decay divider needs at least one bit, even when DECAY_DIV=1.
    localparam int DC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECAY_DIV - 1);

    logic [LEVEL_W-1:0] pwm_cnt;
    logic [DC_W-1:0]    decay_cnt;
    logic [LEVEL_W-1:0] level  [N_LEDS];
    logic [LEVEL_W-1:0] shadow [N_LEDS];

    logic pwm_last;
    logic decay_step;

    assign pwm_last   = (pwm_cnt == PWM_LAST);
    assign decay_step = (decay_cnt == DC_LAST);

    // Maps a brightness level to a duty in PWM counts (0..MAX).
    function automatic logic [LEVEL_W-1:0] duty(input logic [LEVEL_W-1:0] l);
`ifdef LED_GAMMA_EN
        return LEVEL_W'(({{LEVEL_W{1'b0}}, l} * {{LEVEL_W{1'b0}}, l} + MAX_M1_W) / MAX_W);
`else
        return l;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (clear) begin
            pwm_cnt     <= '0;
            decay_cnt   <= '0;
            led_out     <= '0;
            frame_pulse <= 1'b0;
            for (int i = 0; i < N_LEDS; i++) begin
                level[i]  <= '0;
                shadow[i] <= '0;
            end
        end else begin
            pwm_cnt     <= pwm_last ? '0 : pwm_cnt + 1'b1;
            frame_pulse <= (pwm_cnt == '0);

            for (int i = 0; i < N_LEDS; i++) begin
                led_out[i] <= (pwm_cnt < shadow[i]);
            end

            // The shadow reads the level before this edge's NBA update. A step
            // on the same edge shows up only after the following period.
            if (pwm_last) begin
                for (int i = 0; i < N_LEDS; i++) begin
                    shadow[i] <= duty(level[i]);
                end
            end

            if (step) begin
                decay_cnt <= decay_step ? '0 : decay_cnt + 1'b1;
                for (int i = 0; i < N_LEDS; i++) begin
                    if (pattern[i]) begin
                        level[i] <= MAX;
                    end else if (decay_step && (level[i] != '0)) begin
                        level[i] <= level[i] - 1'b1;
                    end
                end
            end
        end
    end

endmodule
